key_sw_io_device: RTL
=====================

# key_sw_io_device

Memory-mapped responder for the processor's KEY and SW inputs, sitting on the data-memory bus beside D-MEM, the HEX register and the LEDR register. It synchronizes the raw board inputs and holds them in data registers. It flags changes through ready/overrun status bits and answers CPU loads and stores at four word addresses. An interrupt request line is driven for the future interrupt controller.

## Interface
Parameters:
- DBITS, 32, bus data/address width
- KEYBITS, 4, KEY input width
- SWBITS, 10, SW input width
- ADDRKEY, 32'hFFFFF080, KDATA address; KCTRL is ADDRKEY+4
- ADDRSW, 32'hFFFFF090, SDATA address; SCTRL is ADDRSW+4
- DEBOUNCE_CYCLES, 500000, stable-cycle count required before an SW change is accepted

Ports:
- clk  in  1  processor clock (PLL output); all state updates on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- KEY  in  KEYBITS  raw keys, active-low
- SW  in  SWBITS  raw switches, active-high
- addr  in  DBITS  bus address (the MEM-stage ALU output)
- re  in  1  load in progress
- we  in  1  store in progress
- wdata  in  DBITS  store data
- rdata  out  DBITS  read data; 0 when no address hit
- hit  out  1  addr matches one of the four registers (steers the MEM-stage read mux)
- intr  out  1  interrupt request

## Operation
- Each input bus has a 2-flop synchronizer. The KEY synchronizer captures ~KEY, so a pressed key reads as 1.
- KDATA holds KEYBITS bits, zero-extended on read. It loads the synchronized keys whenever they differ from the held value (a key event).
- SDATA holds SWBITS bits, zero-extended on read. It loads on an SW event (see Configuration).
- KCTRL/SCTRL bit layout, same for both: bit0 READY (read-only), bit2 OVERRUN, bit8 IE (read/write). All other bits read 0.
- Event while READY=0: READY is set.
- Event while READY=1: OVERRUN is set and READY stays 1.
- A load of a DATA register (re, address match) clears READY in that cycle.
- If a load and an event hit the same register in the same cycle:
  - READY ends at 1.
  - OVERRUN is not set.
  - rdata returns the old value.
- Store to a CTRL register:
  - IE is written from wdata[8].
  - wdata[2]=0 clears OVERRUN; wdata[2]=1 leaves it unchanged.
  - wdata[0] is ignored.
  - If a store that sets OVERRUN coincides with an overrun event, OVERRUN stays 1.
- Stores to DATA registers are ignored.
- intr = (KREADY & KIE) | (SREADY & SIE).
- re and we together: the write side effect applies and the read side effect applies, each per the rules above.

## Timing
- rdata and hit are combinational from addr and register state, so a load completes in the MEM stage with no wait states.
- All side effects (READY clear, CTRL write) occur at the rising edge that ends the access cycle.
- Input-to-KDATA latency: 3 clk (two synchronizer stages plus the register).
- Input-to-SDATA latency: 3 clk plus the debounce interval when debounce is enabled.
- READY and intr assert in the same cycle the DATA register updates.
- Reset values, applied on RESET_N low asynchronously:
  - synchronizers, KDATA, SDATA, all CTRL bits and the debounce counter = 0
  - intr = 0
  - rdata = 0, unless a hit address is presented
- Reset during a pending debounce discards the pending change.

## Configuration
- KEYSW_DEBOUNCE_EN defined:
  - While the synchronized SW differs from SDATA, a counter increments each cycle.
  - The counter restarts at 0 whenever the synchronized SW value changes from the previous cycle.
  - When the counter reaches DEBOUNCE_CYCLES-1 and SW still differs from SDATA, SDATA loads, the event fires, and the counter returns to 0.
  - When SW equals SDATA, the counter is held at 0.
  - The counter is $clog2(DEBOUNCE_CYCLES) bits wide.
- KEYSW_DEBOUNCE_EN undefined: no counter; SW events fire exactly like KEY events.
- KEY is never debounced.

## Structure
- Package keysw_pkg holds:
  - the register offsets (DATA 0, CTRL 4)
  - the CTRL bit indices (READY 0, OVERRUN 2, IE 8)
  - a typedef for the CTRL register struct
- One sub-module, sw_debounce: synchronized SW in; accepted value and event pulse out; contains the counter under KEYSW_DEBOUNCE_EN.

## Test plan
- Reset then idle: KEY=4'hF, SW=0 → load 0xFFFFF080 returns 0, load 0xFFFFF084 returns 0, intr=0, hit=1 on both.
- Press KEY0 (KEY=4'hE) → 3 clk later KDATA=1 and KCTRL=0x1; load of KDATA returns 1; next cycle KCTRL=0x0.
- Two key events without a read (KEY=E, then C) → KDATA=3, KCTRL=0x5; store 0 to KCTRL clears OVERRUN, giving 0x1.
- Store 0x100 to SCTRL, then set SW=0x2A3 steady → SDATA=0x2A3 after 3+DEBOUNCE_CYCLES clk with debounce (3 clk without), intr rises with READY. An SW glitch shorter than DEBOUNCE_CYCLES causes no event.
- Load of KDATA in the same cycle as a key event → old value returned, KCTRL=0x1 afterwards, OVERRUN=0.
- Load of unmapped 0xFFFFF0A0 → hit=0, rdata=0. Assert RESET_N=0 mid-debounce with READY set → all registers 0 immediately.

Source files
------------

// File: rtl/keysw_pkg.sv
// Shared register map, CTRL bit positions and CTRL update rule for the KEY/SW I/O device.
package keysw_pkg;

  localparam int unsigned OFS_DATA    = 0;
  localparam int unsigned OFS_CTRL    = 4;

  localparam int unsigned READY_BIT   = 0;
  localparam int unsigned OVERRUN_BIT = 2;
  localparam int unsigned IE_BIT      = 8;

  typedef struct packed {
    logic ie;
    logic overrun;
    logic ready;
  } ctrl_t;

  function automatic logic [IE_BIT:0] ctrl_word(input ctrl_t c);
    logic [IE_BIT:0] w;
    w              = '0;
    w[READY_BIT]   = c.ready;
    w[OVERRUN_BIT] = c.overrun;
    w[IE_BIT]      = c.ie;
    return w;
  endfunction

  // An event always leaves READY set; a load racing an event does not count as an overrun.
  function automatic ctrl_t ctrl_next(input ctrl_t q, input logic evt, input logic rd,
                                      input logic wr, input logic wr_ovr, input logic wr_ie);
    ctrl_t n;
    n = q;
    if (wr) begin
      n.ie = wr_ie;
      if (!wr_ovr) n.overrun = 1'b0;
    end
    if (evt) begin
      if (q.ready && !rd) n.overrun = 1'b1;
      n.ready = 1'b1;
    end else if (rd) begin
      n.ready = 1'b0;
    end
    return n;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Accepts the synchronized switch value, optionally after it has been stable for
// DEBOUNCE_CYCLES cycles (build with KEYSW_DEBOUNCE_EN defined).
module sw_debounce #(
  parameter int SWBITS          = 10,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SWBITS-1:0] sw_sync,
  output logic [SWBITS-1:0] sw_acc,
  output logic              sw_evt
);

  logic [SWBITS-1:0] acc_q, acc_d;

`ifdef KEYSW_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SWBITS-1:0] prev_q, prev_d;

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    prev_d = sw_sync;
    sw_evt = 1'b0;
    if (sw_sync == acc_q) begin
      cnt_d = '0;
    end else if (sw_sync != prev_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      acc_d  = sw_sync;
      sw_evt = 1'b1;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      prev_q <= '0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      prev_q <= prev_d;
    end
  end
`else
  always_comb begin
    acc_d  = sw_sync;
    sw_evt = (sw_sync != acc_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end
`endif

  assign sw_acc = acc_q;

endmodule

// File: rtl/key_sw_io_device.sv
// Memory-mapped KEY/SW responder: KDATA/KCTRL at ADDRKEY, SDATA/SCTRL at ADDRSW.
// SW debounce is enabled by defining KEYSW_DEBOUNCE_EN.
module key_sw_io_device
  import keysw_pkg::*;
#(
  parameter int               DBITS           = 32,
  parameter int               KEYBITS         = 4,
  parameter int               SWBITS          = 10,
  parameter logic [DBITS-1:0] ADDRKEY         = 32'hFFFFF080,
  parameter logic [DBITS-1:0] ADDRSW          = 32'hFFFFF090,
  parameter int               DEBOUNCE_CYCLES = 500000
) (
  input  logic               clk,
  input  logic               RESET_N,
  input  logic [KEYBITS-1:0] KEY,
  input  logic [SWBITS-1:0]  SW,
  input  logic [DBITS-1:0]   addr,
  input  logic               re,
  input  logic               we,
  input  logic [DBITS-1:0]   wdata,
  output logic [DBITS-1:0]   rdata,
  output logic               hit,
  output logic               intr
);

  localparam logic [DBITS-1:0] A_KDATA = ADDRKEY + DBITS'(OFS_DATA);
  localparam logic [DBITS-1:0] A_KCTRL = ADDRKEY + DBITS'(OFS_CTRL);
  localparam logic [DBITS-1:0] A_SDATA = ADDRSW + DBITS'(OFS_DATA);
  localparam logic [DBITS-1:0] A_SCTRL = ADDRSW + DBITS'(OFS_CTRL);

  logic [KEYBITS-1:0] key_s1_q, key_s1_d, key_s2_q, key_s2_d;
  logic [KEYBITS-1:0] kdata_q, kdata_d;
  logic [SWBITS-1:0]  sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic [SWBITS-1:0]  sdata;
  ctrl_t              kctrl_q, kctrl_d, sctrl_q, sctrl_d;
  logic               key_evt, sw_evt;
  logic               hit_kd, hit_kc, hit_sd, hit_sc;

  sw_debounce #(
    .SWBITS          (SWBITS),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_debounce (
    .clk     (clk),
    .rst_n   (RESET_N),
    .sw_sync (sw_s2_q),
    .sw_acc  (sdata),
    .sw_evt  (sw_evt)
  );

  assign hit_kd = (addr == A_KDATA);
  assign hit_kc = (addr == A_KCTRL);
  assign hit_sd = (addr == A_SDATA);
  assign hit_sc = (addr == A_SCTRL);
  assign hit    = hit_kd | hit_kc | hit_sd | hit_sc;

  always_comb begin
    rdata = '0;
    if (hit_kd) rdata = DBITS'(kdata_q);
    if (hit_kc) rdata = DBITS'(ctrl_word(kctrl_q));
    if (hit_sd) rdata = DBITS'(sdata);
    if (hit_sc) rdata = DBITS'(ctrl_word(sctrl_q));
  end

  assign intr = (kctrl_q.ready & kctrl_q.ie) | (sctrl_q.ready & sctrl_q.ie);

  // Keys are active-low on the board; invert at capture so pressed reads as 1.
  always_comb begin
    key_s1_d = ~KEY;
    key_s2_d = key_s1_q;
    sw_s1_d  = SW;
    sw_s2_d  = sw_s1_q;
    key_evt  = (key_s2_q != kdata_q);
    kdata_d  = key_s2_q;
    kctrl_d  = ctrl_next(kctrl_q, key_evt, re & hit_kd, we & hit_kc,
                         wdata[OVERRUN_BIT], wdata[IE_BIT]);
    sctrl_d  = ctrl_next(sctrl_q, sw_evt, re & hit_sd, we & hit_sc,
                         wdata[OVERRUN_BIT], wdata[IE_BIT]);
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      key_s1_q <= '0;
      key_s2_q <= '0;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      kdata_q  <= '0;
      kctrl_q  <= '0;
      sctrl_q  <= '0;
    end else begin
      key_s1_q <= key_s1_d;
      key_s2_q <= key_s2_d;
      sw_s1_q  <= sw_s1_d;
      sw_s2_q  <= sw_s2_d;
      kdata_q  <= kdata_d;
      kctrl_q  <= kctrl_d;
      sctrl_q  <= sctrl_d;
    end
  end

endmodule
